// File: rtl/atm_pkg.sv
// Shared definitions for the ATM balance arbiter: operation codes,
// arbiter state encoding and the amount/balance width.
package atm_pkg;

   localparam int AMT_W = 16;

   typedef enum logic [1:0] {
      OP_BAL = 2'b00,
      OP_WDR = 2'b01,
      OP_DEP = 2'b10,
      OP_INV = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_GRANT = 2'b01,
      ST_EXEC  = 2'b10,
      ST_RESP  = 2'b11
   } arb_state_e;

   // Result of one executed transaction: status flag plus resulting balance.
   typedef struct packed {
      logic             ok;
      logic [AMT_W-1:0] bal;
   } exec_res_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The priority bit names the terminal that wins
// a tie; it moves to the other terminal whenever a winner is accepted.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       adv,
   output logic [1:0] win
);

   logic prio;

   // Pick the single requester, or on a tie the terminal holding priority.
   always_comb begin
      win = 2'b00;
      case (req)
         2'b01:   win = 2'b01;
         2'b10:   win = 2'b10;
         2'b11:   win = prio ? 2'b10 : 2'b01;
         default: win = 2'b00;
      endcase
   end

   // Hand priority to the terminal that was not just served.
   always_ff @(posedge clk) begin
      if (rst)
         prio <= 1'b0;
      else if (adv && (win != 2'b00))
         prio <= win[0];
   end

endmodule

// File: rtl/atm_balance_arbiter.sv
// Two-terminal ATM front end: arbitrates between terminals, captures the
// winner's operation, updates a shared balance and reports the outcome.
module atm_balance_arbiter
   import atm_pkg::*;
#(
   parameter logic [AMT_W-1:0] INIT_BALANCE = 16'd1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req,
   input  logic [1:0]       op0,
   input  logic [AMT_W-1:0] amt0,
   input  logic [1:0]       op1,
   input  logic [AMT_W-1:0] amt1,
   output logic [1:0]       gnt,
   output logic [1:0]       done,
   output logic             ok,
   output logic [AMT_W-1:0] bal_out,
   output logic             busy
);

   arb_state_e       state;
   arb_state_e       state_nxt;
   logic [1:0]       win_rr;
   logic [1:0]       winner_q;
   logic             adv;
   op_e              op_p0;
   logic [AMT_W-1:0] amt_p0;
   logic [AMT_W-1:0] balance;
   logic             ok_q;
   exec_res_t        res;

   // Apply one operation to a balance; failed operations leave it untouched.
   function automatic exec_res_t exec_op(input op_e op,
                                         input logic [AMT_W-1:0] amt,
                                         input logic [AMT_W-1:0] bal);
      exec_res_t        r;
      logic [AMT_W:0]   sum;
      sum   = {1'b0, bal} + {1'b0, amt};
      r.ok  = 1'b0;
      r.bal = bal;
      case (op)
         OP_BAL: r.ok = 1'b1;
         OP_WDR: begin
            if (amt <= bal) begin
               r.ok  = 1'b1;
               r.bal = bal - amt;
            end
         end
         OP_DEP: begin
            if (!sum[AMT_W]) begin
               r.ok  = 1'b1;
               r.bal = sum[AMT_W-1:0];
            end
         end
         default: r.ok = 1'b0;
      endcase
      return r;
   endfunction

   // A winner is taken only from IDLE, so requests seen while busy simply wait.
   assign adv = (state == ST_IDLE) && (req != 2'b00);

   rr_arb2 u_rr (
      .clk (clk),
      .rst (rst),
      .req (req),
      .adv (adv),
      .win (win_rr)
   );

   assign res = exec_op(op_p0, amt_p0, balance);

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next state and per-state outputs; outputs are zero outside their state.
   always_comb begin
      state_nxt = state;
      gnt       = 2'b00;
      done      = 2'b00;
      ok        = 1'b0;
      bal_out   = '0;
      busy      = 1'b1;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (req != 2'b00)
               state_nxt = ST_GRANT;
         end
         ST_GRANT: begin
            gnt       = winner_q;
            state_nxt = ST_EXEC;
         end
         ST_EXEC: begin
            state_nxt = ST_RESP;
         end
         ST_RESP: begin
            done      = winner_q;
            ok        = ok_q;
            bal_out   = balance;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Latch the arbitration winner for the duration of the transaction.
   always_ff @(posedge clk) begin
      if (rst)
         winner_q <= 2'b00;
      else if (adv)
         winner_q <= win_rr;
   end

   // GRANT stage -> EXEC stage: freeze the winner's operation and amount.
   always_ff @(posedge clk) begin
      if (state == ST_GRANT) begin
         op_p0  <= winner_q[1] ? op_e'(op1) : op_e'(op0);
         amt_p0 <= winner_q[1] ? amt1 : amt0;
      end
   end

   // EXEC stage -> RESP stage: commit the balance and remember the status.
   always_ff @(posedge clk) begin
      if (rst) begin
         balance <= INIT_BALANCE;
         ok_q    <= 1'b0;
      end else if (state == ST_EXEC) begin
         balance <= res.bal;
         ok_q    <= res.ok;
      end
   end

endmodule

// File: tb/tb_atm_balance_arbiter.sv
// Bench for atm_balance_arbiter: directed scenarios plus randomized traffic
// checked against an arithmetic model of the account and round-robin order.
module tb_atm_balance_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req, op0, op1;
   logic [15:0] amt0, amt1;
   logic [1:0]  gnt, done;
   logic        ok;
   logic [15:0] bal_out;
   logic        busy;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model state
   int m_bal;
   int m_prio;

   // observations from the most recent transaction
   logic [1:0]  o_gnt_pre, o_gnt, o_done_pre, o_done;
   logic        o_ok, o_busy_pre, o_busy_mid;
   logic [15:0] o_bal;

   always #5 clk = ~clk;

   atm_balance_arbiter #(.INIT_BALANCE(16'd1000)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .op0     (op0),
      .amt0    (amt0),
      .op1     (op1),
      .amt1    (amt1),
      .gnt     (gnt),
      .done    (done),
      .ok      (ok),
      .bal_out (bal_out),
      .busy    (busy)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic apply_reset();
      rst = 1'b1; req = 2'b00; op0 = 2'b00; op1 = 2'b00; amt0 = '0; amt1 = '0;
      @(posedge clk); @(posedge clk); #1;
      rst    = 1'b0;
      m_bal  = 1000;
      m_prio = 0;
   endtask

   // One full transaction from IDLE; after GRANT the inputs are scrambled so a
   // late change to op/amt would show up in the result.
   task automatic do_txn(input logic [1:0] r, input logic [1:0] p0, input logic [15:0] a0,
                         input logic [1:0] p1, input logic [15:0] a1, input logic [15:0] late);
      @(posedge clk); #1;
      req = r; op0 = p0; amt0 = a0; op1 = p1; amt1 = a1;
      @(negedge clk);
      o_gnt_pre = gnt; o_busy_pre = busy; o_done_pre = done;
      @(negedge clk);
      o_gnt = gnt; o_busy_mid = busy; o_done_pre = o_done_pre | done;
      @(posedge clk); #1;
      amt0 = late; amt1 = late; op0 = 2'($urandom); op1 = 2'($urandom);
      @(negedge clk);
      o_done_pre = o_done_pre | done;
      @(negedge clk);
      o_done = done; o_ok = ok; o_bal = bal_out;
      @(posedge clk); #1;
      req = 2'b00;
   endtask

   task automatic test_reset();
      apply_reset();
      @(negedge clk);
      n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
      n_cmp++; if (done !== 2'b00) begin n_fail++; $display("FAIL reset_done: got %b expected 00", done); end
      n_cmp++; if (ok !== 1'b0) begin n_fail++; $display("FAIL reset_ok: got %b expected 0", ok); end
      n_cmp++; if (bal_out !== 16'd0) begin n_fail++; $display("FAIL reset_bal_out: got %0d expected 0", bal_out); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
   endtask

   task automatic test_withdraw();
      do_txn(2'b01, 2'b01, 16'd300, 2'b00, 16'd0, 16'h1234);
      n_cmp++; if (o_gnt_pre !== 2'b00 || o_busy_pre !== 1'b0) begin n_fail++; $display("FAIL wdr_idle: gnt %b busy %b expected 00/0", o_gnt_pre, o_busy_pre); end
      n_cmp++; if (o_gnt !== 2'b01) begin n_fail++; $display("FAIL wdr_gnt: got %b expected 01", o_gnt); end
      n_cmp++; if (o_busy_mid !== 1'b1) begin n_fail++; $display("FAIL wdr_busy: got %b expected 1", o_busy_mid); end
      n_cmp++; if (o_done_pre !== 2'b00) begin n_fail++; $display("FAIL wdr_early_done: got %b expected 00", o_done_pre); end
      n_cmp++; if (o_done !== 2'b01) begin n_fail++; $display("FAIL wdr_done: got %b expected 01", o_done); end
      n_cmp++; if (o_ok !== 1'b1 || o_bal !== 16'd700) begin n_fail++; $display("FAIL wdr_result: got ok %b bal %0d expected 1/700", o_ok, o_bal); end
   endtask

   task automatic test_insufficient();
      do_txn(2'b10, 2'b00, 16'd0, 2'b01, 16'd701, 16'd1);
      n_cmp++; if (o_done !== 2'b10) begin n_fail++; $display("FAIL insuf_done: got %b expected 10", o_done); end
      n_cmp++; if (o_ok !== 1'b0 || o_bal !== 16'd700) begin n_fail++; $display("FAIL insuf_result: got ok %b bal %0d expected 0/700", o_ok, o_bal); end
      do_txn(2'b10, 2'b00, 16'd0, 2'b01, 16'd700, 16'd3);
      n_cmp++; if (o_ok !== 1'b1 || o_bal !== 16'd0) begin n_fail++; $display("FAIL wdr_all: got ok %b bal %0d expected 1/0", o_ok, o_bal); end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_g;
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         do_txn(2'b11, 2'b10, 16'd10, 2'b10, 16'd10, 16'd7);
         n_cmp++; if (o_gnt !== exp_g || o_done !== exp_g) begin n_fail++; $display("FAIL rr_order[%0d]: got gnt %b done %b expected %b", k, o_gnt, o_done, exp_g); end
         n_cmp++; if (o_bal !== 16'(1010 + 10 * k)) begin n_fail++; $display("FAIL rr_bal[%0d]: got %0d expected %0d", k, o_bal, 1010 + 10 * k); end
      end
   endtask

   task automatic test_overflow();
      apply_reset();
      do_txn(2'b01, 2'b10, 16'd64520, 2'b00, 16'd0, 16'd0);
      n_cmp++; if (o_ok !== 1'b1 || o_bal !== 16'hFFF0) begin n_fail++; $display("FAIL ovf_setup: got ok %b bal %h expected 1/fff0", o_ok, o_bal); end
      do_txn(2'b10, 2'b00, 16'd0, 2'b10, 16'd15, 16'd9);
      n_cmp++; if (o_ok !== 1'b1 || o_bal !== 16'hFFFF) begin n_fail++; $display("FAIL dep_to_max: got ok %b bal %h expected 1/ffff", o_ok, o_bal); end
      do_txn(2'b01, 2'b10, 16'd1, 2'b00, 16'd0, 16'd0);
      n_cmp++; if (o_ok !== 1'b0 || o_bal !== 16'hFFFF) begin n_fail++; $display("FAIL dep_overflow: got ok %b bal %h expected 0/ffff", o_ok, o_bal); end
      do_txn(2'b01, 2'b11, 16'd5, 2'b00, 16'd0, 16'd0);
      n_cmp++; if (o_ok !== 1'b0 || o_bal !== 16'hFFFF) begin n_fail++; $display("FAIL op_invalid: got ok %b bal %h expected 0/ffff", o_ok, o_bal); end
      do_txn(2'b01, 2'b01, 16'd0, 2'b00, 16'd0, 16'd77);
      n_cmp++; if (o_ok !== 1'b1 || o_bal !== 16'hFFFF) begin n_fail++; $display("FAIL wdr_zero: got ok %b bal %h expected 1/ffff", o_ok, o_bal); end
      do_txn(2'b10, 2'b00, 16'd0, 2'b10, 16'd0, 16'd77);
      n_cmp++; if (o_ok !== 1'b1 || o_bal !== 16'hFFFF) begin n_fail++; $display("FAIL dep_zero: got ok %b bal %h expected 1/ffff", o_ok, o_bal); end
   endtask

   task automatic test_reset_abort();
      logic [1:0] seen;
      apply_reset();
      @(posedge clk); #1;
      req = 2'b01; op0 = 2'b01; amt0 = 16'd100;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      seen = done;
      @(posedge clk); #1;
      rst = 1'b0; req = 2'b00;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         seen = seen | done;
      end
      n_cmp++; if (seen !== 2'b00) begin n_fail++; $display("FAIL abort_done: got %b expected 00", seen); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
      do_txn(2'b01, 2'b00, 16'd0, 2'b00, 16'd0, 16'd0);
      n_cmp++; if (o_ok !== 1'b1 || o_bal !== 16'd1000) begin n_fail++; $display("FAIL abort_bal: got ok %b bal %0d expected 1/1000", o_ok, o_bal); end
   endtask

   task automatic test_amt_change();
      apply_reset();
      do_txn(2'b10, 2'b00, 16'd0, 2'b01, 16'd50, 16'd900);
      n_cmp++; if (o_done !== 2'b10 || o_ok !== 1'b1 || o_bal !== 16'd950) begin n_fail++; $display("FAIL late_amt: got done %b ok %b bal %0d expected 10/1/950", o_done, o_ok, o_bal); end
   endtask

   // Terminal 1 raises its request mid-transaction and must be served next.
   task automatic test_back_to_back();
      @(posedge clk); #1;
      req = 2'b01; op0 = 2'b10; amt0 = 16'd50; op1 = 2'b01; amt1 = 16'd1000;
      @(posedge clk); #1;
      req = 2'b11;
      @(negedge clk);
      n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL b2b_gnt0: got %b expected 01", gnt); end
      @(negedge clk); @(negedge clk);
      n_cmp++; if (done !== 2'b01 || bal_out !== 16'd1000) begin n_fail++; $display("FAIL b2b_done0: got done %b bal %0d expected 01/1000", done, bal_out); end
      @(posedge clk); #1;
      req = 2'b10;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || gnt !== 2'b00) begin n_fail++; $display("FAIL b2b_idle: got busy %b gnt %b expected 0/00", busy, gnt); end
      @(negedge clk);
      n_cmp++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL b2b_gnt1: got %b expected 10", gnt); end
      @(negedge clk); @(negedge clk);
      n_cmp++; if (done !== 2'b10 || ok !== 1'b1 || bal_out !== 16'd0) begin n_fail++; $display("FAIL b2b_done1: got done %b ok %b bal %0d expected 10/1/0", done, ok, bal_out); end
      @(posedge clk); #1;
      req = 2'b00;
   endtask

   task automatic test_random();
      logic [1:0]  r, p0, p1, wop;
      logic [15:0] a0, a1, wamt;
      logic [1:0]  exp_g;
      int          w, exp_ok, mode;
      apply_reset();
      for (int t = 0; t < 40; t++) begin
         r  = 2'($urandom_range(1, 3));
         p0 = 2'($urandom_range(0, 3));
         p1 = 2'($urandom_range(0, 3));
         mode = $urandom_range(0, 4);
         case (mode)
            0: begin a0 = 16'($urandom); a1 = 16'($urandom); end
            1: begin a0 = 16'(m_bal); a1 = 16'(m_bal); end
            2: begin a0 = 16'd0; a1 = 16'd0; end
            3: begin a0 = 16'(65535 - m_bal); a1 = 16'(65535 - m_bal); end
            default: begin a0 = 16'($urandom_range(0, 500)); a1 = 16'($urandom_range(0, 500)); end
         endcase
         w    = (r == 2'b11) ? m_prio : ((r == 2'b10) ? 1 : 0);
         wop  = (w == 1) ? p1 : p0;
         wamt = (w == 1) ? a1 : a0;
         exp_ok = 0;
         if (wop == 2'b00) exp_ok = 1;
         else if (wop == 2'b01 && int'(wamt) <= m_bal) begin exp_ok = 1; m_bal = m_bal - int'(wamt); end
         else if (wop == 2'b10 && m_bal + int'(wamt) <= 65535) begin exp_ok = 1; m_bal = m_bal + int'(wamt); end
         if (r == 2'b11) m_prio = 1 - w;
         else m_prio = 1 - w;
         exp_g = (w == 1) ? 2'b10 : 2'b01;
         do_txn(r, p0, a0, p1, a1, 16'($urandom));
         n_cmp++; if (o_gnt !== exp_g || o_done !== exp_g) begin n_fail++; $display("FAIL rand_winner[%0d]: got gnt %b done %b expected %b", t, o_gnt, o_done, exp_g); end
         n_cmp++; if (o_ok !== 1'(exp_ok) || o_bal !== 16'(m_bal)) begin n_fail++; $display("FAIL rand_result[%0d]: got ok %b bal %0d expected %0d/%0d", t, o_ok, o_bal, exp_ok, m_bal); end
      end
   endtask

   initial begin
      test_reset();
      test_withdraw();
      test_insufficient();
      test_round_robin();
      test_overflow();
      test_reset_abort();
      test_amt_change();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
